// File: rtl/hbm_clk_mon_pkg.sv
// hbm_clk_mon_pkg: monitor state type, default parameters and counter width helper
`timescale 1ns/1ps
package hbm_clk_mon_pkg;

    typedef enum logic [1:0] {SEARCH, LOCKED, LOST} mon_state_e;

    localparam int WINDOW_CYCLES_D   = 1000;
    localparam int EXP_EDGES_D       = 400;
    localparam int EDGE_TOL_D        = 4;
    localparam int LOCK_WINDOWS_D    = 4;
    localparam int LOS_CYCLES_D      = 16;
    localparam int DIFF_ERR_CYCLES_D = 3;

    function automatic int cnt_w(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/hbm_clk_mon_sync.sv
// hbm_clk_sync: two-flop synchronizer for both clock legs plus p rising-edge detect
`timescale 1ns/1ps
module hbm_clk_sync (
    input  logic axis_aclk,
    input  logic rst_n,
    input  logic hbm_clk_p,
    input  logic hbm_clk_n,
    output logic sync_p,
    output logic sync_n,
    output logic p_rise
);

    logic p_meta, n_meta, p_dly;

    // synchronize both legs; reset to the stopped-clock pattern (p low, n high)
    always_ff @(posedge axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            p_meta <= 1'b0;
            sync_p <= 1'b0;
            p_dly  <= 1'b0;
            n_meta <= 1'b1;
            sync_n <= 1'b1;
        end else begin
            p_meta <= hbm_clk_p;
            sync_p <= p_meta;
            p_dly  <= sync_p;
            n_meta <= hbm_clk_n;
            sync_n <= n_meta;
        end
    end

    assign p_rise = sync_p & ~p_dly;

endmodule

// File: rtl/hbm_clk_mon.sv
// hbm_clk_mon: frequency, complementarity and loss-of-signal checker for the HBM reference clock
`timescale 1ns/1ps
module hbm_clk_mon
    import hbm_clk_mon_pkg::*;
#(
    parameter int WINDOW_CYCLES   = WINDOW_CYCLES_D,
    parameter int EXP_EDGES       = EXP_EDGES_D,
    parameter int EDGE_TOL        = EDGE_TOL_D,
    parameter int LOCK_WINDOWS    = LOCK_WINDOWS_D,
    parameter int LOS_CYCLES      = LOS_CYCLES_D,
    parameter int DIFF_ERR_CYCLES = DIFF_ERR_CYCLES_D,
    localparam int CNT_W          = cnt_w(WINDOW_CYCLES)
) (
    input  logic             axis_aclk,
    input  logic             rst_n,
    input  logic             hbm_clk_p,
    input  logic             hbm_clk_n,
    input  logic             clear_sticky,
    output logic             clk_locked,
    output logic             lost_sticky,
    output logic             diff_err_sticky,
    output logic [CNT_W-1:0] edge_count,
    output logic             window_valid,
    output logic [15:0]      loss_count
);

    localparam int WIN_W  = $clog2(WINDOW_CYCLES);
    localparam int CW1    = CNT_W + 1;
    localparam int LOS_W  = $clog2(LOS_CYCLES + 1);
    localparam int DIFF_W = $clog2(DIFF_ERR_CYCLES + 1);
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

    logic              sync_p, sync_n, p_rise;
    logic [WIN_W-1:0]  win_cnt;
    logic [CNT_W-1:0]  edge_cnt, edge_inc, win_sat;
    logic [CW1-1:0]    win_total;
    logic [LOS_W-1:0]  los_tmr;
    logic [DIFF_W-1:0] diff_cnt;
    logic [GOOD_W-1:0] good_cnt, good_nxt;
    logic              wrap, restart, los, eq, diff_err, diff_win, good_win, bad_win, lost_set;
    mon_state_e        state, state_nxt;

    hbm_clk_sync u_sync (
        .axis_aclk (axis_aclk),
        .rst_n     (rst_n),
        .hbm_clk_p (hbm_clk_p),
        .hbm_clk_n (hbm_clk_n),
        .sync_p    (sync_p),
        .sync_n    (sync_n),
        .p_rise    (p_rise)
    );

    assign wrap      = win_cnt == WIN_W'(WINDOW_CYCLES - 1);
    assign restart   = (state == LOST) && p_rise;
    assign win_total = {1'b0, edge_cnt} + CW1'(p_rise);
    assign win_sat   = win_total[CNT_W] ? '1 : win_total[CNT_W-1:0];
    assign edge_inc  = (p_rise && edge_cnt != '1) ? edge_cnt + 1'b1 : edge_cnt;
    assign los       = los_tmr >= LOS_W'(LOS_CYCLES);
    assign eq        = sync_p == sync_n;
    assign diff_err  = eq && diff_cnt == DIFF_W'(DIFF_ERR_CYCLES - 1);
    assign good_win  = win_total >= CW1'(EXP_EDGES - EDGE_TOL) && win_total <= CW1'(EXP_EDGES + EDGE_TOL)
                       && !diff_win && !diff_err;
    assign bad_win   = wrap && !good_win;
    assign clk_locked = state == LOCKED;

    // measurement window; a recovery from LOST realigns it to the first returning edge
    always_ff @(posedge axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt      <= '0;
            edge_cnt     <= '0;
            edge_count   <= '0;
            window_valid <= 1'b0;
            diff_win     <= 1'b0;
        end else begin
            win_cnt      <= (wrap || restart) ? '0 : win_cnt + 1'b1;
            edge_cnt     <= restart ? CNT_W'(1) : wrap ? CNT_W'(p_rise) : edge_inc;
            edge_count   <= wrap ? win_sat : edge_count;
            window_valid <= wrap;
            diff_win     <= (wrap || restart) ? 1'b0 : diff_win | diff_err;
        end
    end

    // loss-of-signal timer and p==n run-length counter, both saturating
    always_ff @(posedge axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            los_tmr  <= '0;
            diff_cnt <= '0;
        end else begin
            los_tmr  <= p_rise ? '0 : los ? los_tmr : los_tmr + 1'b1;
            diff_cnt <= !eq ? '0 : (diff_cnt == DIFF_W'(DIFF_ERR_CYCLES)) ? diff_cnt : diff_cnt + 1'b1;
        end
    end

    // state register plus sticky status and loss counter; a set beats a same-cycle clear
    always_ff @(posedge axis_aclk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= SEARCH;
            good_cnt        <= '0;
            lost_sticky     <= 1'b0;
            diff_err_sticky <= 1'b0;
            loss_count      <= '0;
        end else begin
            state           <= state_nxt;
            good_cnt        <= good_nxt;
            lost_sticky     <= lost_set | (lost_sticky & ~clear_sticky);
            diff_err_sticky <= diff_err | (diff_err_sticky & ~clear_sticky);
            loss_count      <= (lost_set && loss_count != 16'hFFFF) ? loss_count + 1'b1 : loss_count;
        end
    end

    // next state: qualify windows in SEARCH, drop to LOST on any fault once, recover on first edge
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        lost_set  = 1'b0;
        case (state)
            SEARCH: begin
                if (diff_err) begin
                    good_nxt = '0;
                end else if (good_cnt == GOOD_W'(LOCK_WINDOWS)) begin
                    state_nxt = LOCKED;
                    good_nxt  = '0;
                end else if (wrap) begin
                    good_nxt = good_win ? good_cnt + 1'b1 : '0;
                end
            end
            LOCKED: begin
                if (bad_win || los || diff_err) begin
                    state_nxt = LOST;
                    lost_set  = 1'b1;
                end
            end
            LOST: begin
                if (p_rise) begin
                    state_nxt = SEARCH;
                    good_nxt  = '0;
                end
            end
            default: begin
                state_nxt = SEARCH;
                good_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_hbm_clk_mon.sv
// tb_hbm_clk_mon: directed scoreboard bench for the HBM reference clock monitor
`timescale 1ns/1ps
module tb_hbm_clk_mon;

    localparam int LOS_CYCLES = 16;
    localparam int CNT_W      = 10;

    logic             axis_aclk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear_sticky = 1'b0;
    logic             hbm_clk_p, hbm_clk_n;
    logic             clk_locked, lost_sticky, diff_err_sticky, window_valid;
    logic [CNT_W-1:0] edge_count;
    logic [15:0]      loss_count;

    realtime gen_half = 5.0;
    bit      gen_rst  = 1'b0;
    bit      gen_p    = 1'b0;
    bit      force_eq = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int sb_q[$];

    hbm_clk_mon dut (
        .axis_aclk       (axis_aclk),
        .rst_n           (rst_n),
        .hbm_clk_p       (hbm_clk_p),
        .hbm_clk_n       (hbm_clk_n),
        .clear_sticky    (clear_sticky),
        .clk_locked      (clk_locked),
        .lost_sticky     (lost_sticky),
        .diff_err_sticky (diff_err_sticky),
        .edge_count      (edge_count),
        .window_valid    (window_valid),
        .loss_count      (loss_count)
    );

    always #2 axis_aclk = ~axis_aclk;

    initial begin
        #0.3;
        forever begin
            #(gen_half);
            gen_p = gen_rst ? 1'b0 : ~gen_p;
        end
    end

    assign hbm_clk_p = gen_p;
    assign hbm_clk_n = force_eq ? gen_p : ~gen_p;

    task automatic chk(input string tag, input int obs, input int exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(posedge axis_aclk);
            #1;
            if (window_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_windows(input int exp_e, input int tol, input int nwin, input int lock_at);
        bit got;
        int e;
        for (int k = 1; k <= nwin; k++) begin
            sb_q.push_back(exp_e);
            wait_valid(got);
            e = sb_q.pop_front();
            chk($sformatf("window_seen_%0d", k), int'(got), 1);
            chk_rng($sformatf("edge_count_w%0d", k), int'(edge_count), e - tol, e + tol);
            chk($sformatf("locked_w%0d", k), int'(clk_locked), int'(lock_at != 0 && k >= lock_at));
        end
    endtask

    task automatic pulse_clear();
        @(negedge axis_aclk);
        clear_sticky = 1'b1;
        @(negedge axis_aclk);
        clear_sticky = 1'b0;
        #1;
    endtask

    initial begin
        bit got;
        int n;
        repeat (5) @(negedge axis_aclk);
        chk("rst_locked", int'(clk_locked), 0);
        chk("rst_lost_sticky", int'(lost_sticky), 0);
        chk("rst_diff_sticky", int'(diff_err_sticky), 0);
        chk("rst_edge_count", int'(edge_count), 0);
        chk("rst_window_valid", int'(window_valid), 0);
        chk("rst_loss_count", int'(loss_count), 0);
        rst_n = 1'b1;

        run_windows(400, 1, 5, 5);
        chk("lock_lost_sticky", int'(lost_sticky), 0);
        chk("lock_diff_sticky", int'(diff_err_sticky), 0);

        wait_valid(got);
        chk("pre_los_window_seen", int'(got), 1);
        @(negedge gen_p);
        gen_rst = 1'b1;
        n = 0;
        for (int i = 1; i <= LOS_CYCLES + 4; i++) begin
            @(posedge axis_aclk);
            #1;
            n = i;
            if (!clk_locked) break;
        end
        chk("los_unlocked", int'(clk_locked), 0);
        chk_rng("los_drop_cycles", n, LOS_CYCLES, LOS_CYCLES + 4);
        chk("los_lost_sticky", int'(lost_sticky), 1);
        chk("los_loss_count", int'(loss_count), 1);

        @(negedge axis_aclk);
        gen_rst = 1'b0;
        repeat (10) @(negedge axis_aclk);
        run_windows(400, 1, 5, 5);
        chk("relock_lost_sticky_held", int'(lost_sticky), 1);
        pulse_clear();
        chk("clear_lost_sticky", int'(lost_sticky), 0);

        wait_valid(got);
        chk("pre_diff_window_seen", int'(got), 1);
        @(negedge axis_aclk);
        force_eq = 1'b1;
        repeat (10) @(negedge axis_aclk);
        force_eq = 1'b0;
        #1;
        chk("diff_sticky", int'(diff_err_sticky), 1);
        chk("diff_unlocked", int'(clk_locked), 0);
        chk("diff_loss_count", int'(loss_count), 2);
        repeat (20) @(negedge axis_aclk);
        chk("diff_loss_count_once", int'(loss_count), 2);
        chk("diff_lost_sticky", int'(lost_sticky), 1);
        pulse_clear();
        chk("clear_diff_sticky", int'(diff_err_sticky), 0);
        run_windows(400, 1, 5, 5);

        @(negedge axis_aclk);
        force_eq = 1'b1;
        @(negedge axis_aclk);
        force_eq = 1'b0;
        repeat (10) @(negedge axis_aclk);
        chk("glitch_no_diff", int'(diff_err_sticky), 0);
        chk("glitch_still_locked", int'(clk_locked), 1);
        chk("glitch_loss_count", int'(loss_count), 2);

        @(negedge axis_aclk);
        #0.5 rst_n = 1'b0;
        #0.5;
        chk("async_rst_locked", int'(clk_locked), 0);
        chk("async_rst_edge_count", int'(edge_count), 0);
        chk("async_rst_loss_count", int'(loss_count), 0);
        chk("async_rst_lost_sticky", int'(lost_sticky), 0);
        repeat (3) @(negedge axis_aclk);
        rst_n = 1'b1;
        run_windows(400, 1, 5, 5);

        @(negedge axis_aclk);
        rst_n = 1'b0;
        gen_half = 4.5;
        repeat (5) @(negedge axis_aclk);
        rst_n = 1'b1;
        run_windows(444, 2, 5, 0);
        chk("fast_loss_count", int'(loss_count), 0);
        chk("fast_lost_sticky", int'(lost_sticky), 0);
        chk("fast_diff_sticky", int'(diff_err_sticky), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hbm_clk_mon.md
Name: hbm_clk_mon

Overview:
- Receiver-side checker for the 100 MHz HBM differential reference clock (hbm_clk_p/hbm_clk_n).
- Oversamples both legs in a faster system clock, counts rising edges per fixed window, checks that the two legs stay complementary, and detects clock loss.
- Reports lock and sticky error status for the HBM bring-up logic and for sim scoreboards.
- Sits between the HBM clock source and HBM init control; the HBM init sequence must not start until clk_locked=1.

Parameters:
- WINDOW_CYCLES, 1000: measurement window length, in axis_aclk cycles.
- EXP_EDGES, 400: expected hbm_clk_p rising edges per window (100 MHz sampled by 250 MHz).
- EDGE_TOL, 4: allowed ± deviation from EXP_EDGES.
- LOCK_WINDOWS, 4: consecutive good windows required to declare lock.
- LOS_CYCLES, 16: axis_aclk cycles without any p rising edge that constitute loss of signal.
- DIFF_ERR_CYCLES, 3: consecutive sampled cycles with p==n that constitute a differential error.

Ports:
- axis_aclk  in  1  sampling clock; must be more than 2x the monitored frequency (250 MHz nominal).
- rst_n  in  1  asynchronous, active-low reset.
- hbm_clk_p  in  1  monitored clock, positive leg; asynchronous to axis_aclk.
- hbm_clk_n  in  1  monitored clock, negative leg; asynchronous to axis_aclk.
- clear_sticky  in  1  single-cycle pulse; clears lost_sticky and diff_err_sticky.
- clk_locked  out  1  high while the FSM is in LOCKED.
- lost_sticky  out  1  set on every entry to LOST.
- diff_err_sticky  out  1  set on detection of a differential error.
- edge_count  out  CNT_W  edge count of the last completed window; CNT_W=$clog2(WINDOW_CYCLES+1).
- window_valid  out  1  one-cycle pulse when edge_count updates.
- loss_count  out  16  saturating count of LOCKED->LOST transitions.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0.
  - Synchronizer flops for p reset to 0 and for n reset to 1 (the stopped-clock pattern).
  - FSM enters SEARCH; all counters are 0.
- Sync/edge detect:
  - Each leg passes through 2 sync flops.
  - A third flop on p gives the rising-edge pulse p_rise.
  - Latency from pin edge to p_rise is 2–3 cycles.
- Window counter:
  - Runs free from 0 to WINDOW_CYCLES-1, then wraps.
  - Edge counter increments on p_rise and saturates at its max value.
  - On the wrap cycle: edge_count <= edge counter value plus that cycle's p_rise; window_valid=1; edge counter restarts at 0, or 1 if p_rise.
- Good window: EXP_EDGES-EDGE_TOL <= count <= EXP_EDGES+EDGE_TOL, inclusive bounds, and no diff error during the window.
- LOS timer:
  - Resets to 0 on p_rise, otherwise increments.
  - los = (timer >= LOS_CYCLES); the timer saturates there.
- Diff check:
  - A counter increments while sync_p==sync_n and clears otherwise.
  - diff_err fires when the counter reaches DIFF_ERR_CYCLES.
  - A single-cycle mismatch caused by sync skew is ignored.
- FSM states SEARCH, LOCKED, LOST:
  - SEARCH: a good window increments good_cnt; a bad window clears it. When good_cnt==LOCK_WINDOWS, go to LOCKED and clear good_cnt. diff_err clears good_cnt and sets diff_err_sticky.
  - LOCKED: a bad window, los, or diff_err moves to LOST next cycle. On that transition, set lost_sticky and increment loss_count (saturating at 0xFFFF).
  - LOST: stay while los is asserted. On first p_rise, go to SEARCH with good_cnt=0 and restart the window counter.
- Simultaneous events:
  - Bad window, los, and diff_err in the same cycle count as one loss (loss_count +1).
  - clear_sticky in the same cycle as a set event: set wins.
- clk_locked drops in the cycle after the loss condition is detected.

Decomposition:
- hbm_clk_mon_pkg holds:
  - the state enum mon_state_e {SEARCH, LOCKED, LOST};
  - the default parameter constants;
  - the function cnt_w(window) returning $clog2(window+1).
- Sub-module hbm_clk_sync: 2-flop synchronizer for both legs, reset values p=0 and n=1, plus the p rising-edge detector. Outputs sync_p, sync_n, p_rise.

Test Plan:
- Clock generator running at 10 ns period, axis_aclk 4 ns -> each window_valid shows edge_count=400±1; clk_locked=1 by the 5th window_valid; no sticky bits set.
- Hold the generator's reset low after lock (p=0, n=1 static) -> clk_locked=0 within LOS_CYCLES+4 cycles; lost_sticky=1; loss_count=1.
- Release the generator's reset -> FSM leaves LOST on first edge; clk_locked=1 after 4 good windows; lost_sticky stays 1 until a clear_sticky pulse, then reads 0.
- Force hbm_clk_n=hbm_clk_p for 10 cycles while locked -> diff_err_sticky=1, clk_locked=0, loss_count increments by exactly 1. A 1-cycle forced mismatch -> no error.
- Generator period 9.0 ns (444 edges per window) -> edge_count≈444, clk_locked never asserts, good_cnt stays 0.
- Assert rst_n low mid-LOCKED -> all outputs 0 immediately, with no clock edge needed; relock after release takes LOCK_WINDOWS+1 windows.
